// File: rtl/ear_pulse_capture.sv
// rtl/ear_pulse_capture.sv - EAR deglitcher and pulse-width capture FIFO behind two ZX-Uno registers
module ear_pulse_capture #(
  parameter int         TICK_DIV   = 8,
  parameter int         FILTER_LEN = 4,
  parameter int         FIFO_AW    = 4,
  parameter logic [7:0] ADDR_CTRL  = 8'hE0,
  parameter logic [7:0] ADDR_DATA  = 8'hE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ear,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       ear_filtered
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW    = $clog2(FILTER_LEN);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  logic               sync1_q, sync2_q;
  logic               filt_q, filt_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic               edge_det, edge_q;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tick;
  logic [14:0]        width_q, width_d;
  logic               enable_q, enable_d;
  logic               ovf_q, ovf_d;
  logic               bptr_q, bptr_d;
  logic               regrd_q, regwr_q;
  logic [7:0]         rd_addr_q;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        mem_q [DEPTH];

  logic ctrl_wr, flush, data_rd_end, empty, full, push_req, push, pop;
  logic ctrl_sel, data_sel;
  logic [15:0] head;
  logic [31:0] count_w;
  logic [4:0]  count5;
  logic        unused_din;

  assign unused_din = ^din[7:3];

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = '0;
    edge_det = 1'b0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d   = sync2_q;
        edge_det = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  assign ctrl_wr     = zxuno_regwr & ~regwr_q & (zxuno_addr == ADDR_CTRL);
  assign flush       = ctrl_wr & din[1];
  assign data_rd_end = ~zxuno_regrd & regrd_q & (rd_addr_q == ADDR_DATA);
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign pop         = data_rd_end & ~empty & bptr_q & ~flush;
  // Any CTRL write in the push cycle discards the entry.
  assign push_req    = edge_q & enable_q & ~ctrl_wr;
  assign push        = push_req & (~full | pop);

  always_comb begin
    width_d  = width_q;
    enable_d = enable_q;
    ovf_d    = ovf_q;
    bptr_d   = bptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (!enable_q || flush || edge_q) begin
      width_d = '0;
    end else if (tick && width_q != 15'h7FFF) begin
      width_d = width_q + 15'd1;
    end

    if (ctrl_wr) begin
      enable_d = din[0];
      bptr_d   = 1'b0;
      if (din[2]) ovf_d = 1'b0;
    end else begin
      if (push_req && full && !pop) ovf_d = 1'b1;
      if (data_rd_end && !empty) bptr_d = ~bptr_q;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      filt_q    <= 1'b0;
      fcnt_q    <= '0;
      edge_q    <= 1'b0;
      presc_q   <= '0;
      width_q   <= '0;
      enable_q  <= 1'b0;
      ovf_q     <= 1'b0;
      bptr_q    <= 1'b0;
      regrd_q   <= 1'b0;
      regwr_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      sync1_q   <= ear;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      edge_q    <= edge_det;
      presc_q   <= presc_d;
      width_q   <= width_d;
      enable_q  <= enable_d;
      ovf_q     <= ovf_d;
      bptr_q    <= bptr_d;
      regrd_q   <= zxuno_regrd;
      regwr_q   <= zxuno_regwr;
      if (zxuno_regrd) rd_addr_q <= zxuno_addr;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry records the level that just ended, which is the inverse of the new filtered level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {~filt_q, width_q};
  end

  assign head     = mem_q[rd_ptr_q];
  assign ctrl_sel = zxuno_regrd & (zxuno_addr == ADDR_CTRL);
  assign data_sel = zxuno_regrd & (zxuno_addr == ADDR_DATA);
  assign count_w  = 32'(count_q);
  assign count5   = (count_w > 32'd31) ? 5'h1F : count_w[4:0];

  always_comb begin
    dout = 8'h00;
    if (ctrl_sel) begin
      dout = {count5, 1'b0, empty, ovf_q, enable_q};
    end else if (data_sel && !empty) begin
      dout = bptr_q ? head[15:8] : head[7:0];
    end
  end

  assign oe_n         = ~(ctrl_sel | data_sel);
  assign ear_filtered = filt_q;

endmodule

// File: tb/tb_ear_pulse_capture.sv
// tb/tb_ear_pulse_capture.sv - randomized directed bench for ear_pulse_capture with a queue-based reference model
module tb_ear_pulse_capture;
  localparam int TDIV = 2;
  localparam logic [7:0] A_CTRL = 8'hE0;
  localparam logic [7:0] A_DATA = 8'hE1;

  logic       clk = 1'b0;
  logic       rst_n, ear, regrd, regwr;
  logic [7:0] addr, din, dout;
  logic       oe_n, ear_f;

  ear_pulse_capture #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n), .ear(ear), .zxuno_addr(addr),
    .zxuno_regrd(regrd), .zxuno_regwr(regwr), .din(din),
    .dout(dout), .oe_n(oe_n), .ear_filtered(ear_f)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct { logic [15:0] e; bit cw; } ent_t;
  ent_t mq[$];
  bit   m_ovf, m_en, partial, lvl;
  int   t_last;

  bit mon_en = 0;
  bit saw_high = 0;
  always @(negedge clk) if (mon_en && ear_f) saw_high = 1;

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(string tag, logic [15:0] obs, ent_t x);
    int  d;
    bit  ok;
    d  = int'(obs[14:0]) - int'(x.e[14:0]);
    ok = (obs[15] === x.e[15]);
    if (x.cw) begin
      if (x.e[14:0] == 15'h7FFF) ok = ok && (obs[14:0] == 15'h7FFF);
      else ok = ok && (d >= -1) && (d <= 1);
    end
    n_checks++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (width +/-1)", tag, obs, x.e);
    end
  endtask

  function automatic logic [7:0] model_ctrl();
    int sz = mq.size();
    logic [4:0] c = (sz > 31) ? 5'h1F : 5'(sz);
    return {c, 1'b0, (sz == 0) ? 1'b1 : 1'b0, m_ovf, m_en};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_en = 0; partial = 1; lvl = 0; t_last = cyc;
  endtask

  // Real (non-glitch) EAR change: closes the current level and queues it if capture is on.
  task automatic ear_set(bit v);
    ent_t x;
    int   w;
    if (v == lvl) return;
    ear = v;
    if (m_en) begin
      w = (cyc - t_last) / TDIV;
      if (w > 32767) w = 32767;
      x.e  = {lvl, 15'(w)};
      x.cw = !partial;
      partial = 0;
      if (mq.size() == 16) m_ovf = 1;
      else mq.push_back(x);
    end
    t_last = cyc;
    lvl = v;
  endtask

  task automatic reg_write(logic [7:0] a, logic [7:0] d);
    addr = a; din = d; regwr = 1;
    step(2);
    regwr = 0;
    step(1);
    if (a == A_CTRL) begin
      if (d[0] && !m_en) partial = 1;
      m_en = d[0];
      if (d[1]) begin mq.delete(); partial = 1; end
      if (d[2]) m_ovf = 0;
    end
  endtask

  task automatic reg_read(logic [7:0] a, output logic [7:0] d);
    addr = a; regrd = 1;
    step(1);
    @(negedge clk);
    d = dout;
    chk("oe_n_read", 16'(oe_n), 16'h0);
    step(1);
    regrd = 0;
    step(1);
  endtask

  task automatic read_entry(output logic [15:0] e);
    logic [7:0] lo, hi;
    reg_read(A_DATA, lo);
    reg_read(A_DATA, hi);
    e = {hi, lo};
  endtask

  task automatic chk_ctrl(string tag);
    logic [7:0] d;
    reg_read(A_CTRL, d);
    chk(tag, 16'(d), 16'(model_ctrl()));
  endtask

  task automatic drain(string tag);
    logic [15:0] e;
    ent_t x;
    while (mq.size() > 0) begin
      read_entry(e);
      x = mq.pop_front();
      chk_entry(tag, e, x);
    end
  endtask

  initial begin
    logic [7:0]  d, lo1, lo2, hi;
    ent_t        x;

    rst_n = 0; ear = 0; regrd = 0; regwr = 0; addr = 8'h00; din = 8'h00;
    step(3);
    chk("rst_dout", 16'(dout), 16'h0);
    chk("rst_oe_n", 16'(oe_n), 16'h1);
    chk("rst_ear_f", 16'(ear_f), 16'h0);
    rst_n = 1;
    step(2);
    model_reset();
    chk_ctrl("rst_ctrl");

    // Disabled: filter still follows EAR, nothing queued.
    ear_set(1); step(12);
    chk("dis_ear_f_hi", 16'(ear_f), 16'h1);
    step(20);
    ear_set(0); step(30);
    chk_ctrl("dis_ctrl");

    // T1: random pulse train.
    reg_write(A_CTRL, 8'h01);
    step($urandom_range(20, 100));
    for (int i = 0; i < 8; i++) begin
      ear_set(!lvl);
      step($urandom_range(20, 400));
    end
    chk_ctrl("t1_ctrl");
    drain("t1_entry");
    chk_ctrl("t1_ctrl_empty");

    // T2: short glitches are rejected, a FILTER_LEN glitch is accepted.
    mon_en = 1;
    for (int i = 0; i < 5; i++) begin
      ear = 1; step(2);
      ear = 0; step(48);
    end
    chk("t2_glitch_ear_f", 16'(saw_high), 16'h0);
    chk_ctrl("t2_glitch_ctrl");
    ear_set(1); step(4);
    ear_set(0); step(20);
    mon_en = 0;
    chk("t2_accept_ear_f", 16'(saw_high), 16'h1);
    chk_ctrl("t2_accept_ctrl");
    drain("t2_entry");

    // T3: overflow, clear, full drain, empty reads.
    for (int i = 0; i < 20; i++) begin
      ear_set(!lvl);
      step($urandom_range(12, 40));
    end
    chk_ctrl("t3_full_ctrl");
    reg_write(A_CTRL, 8'h05);
    chk_ctrl("t3_clr_ovf_ctrl");
    drain("t3_entry");
    chk_ctrl("t3_empty_ctrl");
    reg_read(A_DATA, d);
    chk("t3_empty_data0", 16'(d), 16'h0);
    reg_read(A_DATA, d);
    chk("t3_empty_data1", 16'(d), 16'h0);

    // T4: width saturation.
    ear_set(1); step(66000);
    ear_set(0); step(20);
    chk_ctrl("t4_ctrl");
    drain("t4_entry");

    // T5: CTRL write rewinds byte pointer without popping.
    ear_set(1); step(50);
    ear_set(0); step(50);
    reg_read(A_DATA, lo1);
    reg_write(A_CTRL, 8'h01);
    chk_ctrl("t5_ctrl_after_wr");
    reg_read(A_DATA, lo2);
    reg_read(A_DATA, hi);
    x = mq.pop_front();
    chk_entry("t5_first_read", {hi, lo1}, x);
    chk_entry("t5_reread", {hi, lo2}, x);
    drain("t5_entry");
    chk_ctrl("t5_ctrl_end");

    // T6: reset in the middle of a DATA read with entries queued.
    for (int i = 0; i < 5; i++) begin
      ear_set(!lvl);
      step(30);
    end
    chk_ctrl("t6_pre_ctrl");
    reg_read(A_DATA, d);
    addr = A_DATA; regrd = 1;
    step(1);
    rst_n = 0;
    #2;
    regrd = 0;
    ear = 0;
    step(2);
    chk("t6_rst_dout", 16'(dout), 16'h0);
    chk("t6_rst_oe_n", 16'(oe_n), 16'h1);
    chk("t6_rst_ear_f", 16'(ear_f), 16'h0);
    rst_n = 1;
    step(1);
    model_reset();
    step(10);
    chk_ctrl("t6_post_ctrl");
    reg_read(A_DATA, d);
    chk("t6_post_data", 16'(d), 16'h0);
    chk("t6_post_ear_f", 16'(ear_f), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
